// File: rtl/mod_multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS sequencer: opcode/funct codes,
// ALU operation encodings, mux select encodings and the FSM state type.
package mod_multicycle_ctrl_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOP = 3'b101;

  // PC source mux
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // ALU operand B mux
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_R_EXEC   = 4'd3,
    ST_R_WB     = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_FAULT    = 4'd11
  } state_t;

  // Opcode dispatch out of DECODE; ST_FETCH marks an unsupported opcode.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t s;
    case (op)
      OP_RTYPE:     s = ST_R_EXEC;
      OP_LW, OP_SW: s = ST_MEM_ADDR;
      OP_BEQ:       s = ST_BRANCH;
      OP_J:         s = ST_JUMP;
      default:      s = ST_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mod_multicycle_ctrl_if.sv
// Control bundle between the sequencer and the datapath/memory.
// master = sequencer side, slave = datapath/memory side.
interface mod_multicycle_ctrl_if #(parameter int RETIRE_W = 16);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                ir_write;
  logic                pc_en;
  logic [1:0]          pc_source;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [2:0]          alu_op;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                retire;
  logic                illegal;
  logic                fault;
  logic [RETIRE_W-1:0] retire_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           retire, illegal, fault, retire_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           retire, illegal, fault, retire_count
  );
endinterface

// File: rtl/mod_multicycle_ctrl_alu_funct_decode.sv
// R-type funct field to ALU operation, with a flag for supported functs.
module mod_alu_funct_decode
  import mod_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_valid
);

  // Map supported functs; anything else yields a NOP and valid=0.
  always_comb begin
    o_alu_op = ALU_NOP;
    o_valid  = 1'b0;
    case (i_funct)
      FN_ADD:  begin o_alu_op = ALU_ADD; o_valid = 1'b1; end
      FN_SUB:  begin o_alu_op = ALU_SUB; o_valid = 1'b1; end
      FN_AND:  begin o_alu_op = ALU_AND; o_valid = 1'b1; end
      FN_OR:   begin o_alu_op = ALU_OR;  o_valid = 1'b1; end
      FN_SLT:  begin o_alu_op = ALU_SLT; o_valid = 1'b1; end
      default: begin o_alu_op = ALU_NOP; o_valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mod_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer. Moore FSM stepping fetch/decode/execute/
// memory/writeback, with memory-wait timeout into a sticky FAULT state.
module mod_multicycle_ctrl
  import mod_multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT  = 16,
  parameter int RETIRE_W = 16
)(
  input  logic                 clk,
  input  logic                 rst_n,
  mod_multicycle_ctrl_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next;
  state_t              w_dec_next;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_fault;
  logic [RETIRE_W-1:0] r_retire_count;

  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_i_or_d;
  logic       w_ir_write;
  logic       w_pc_en;
  logic [1:0] w_pc_source;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_op;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_retire;
  logic       w_illegal;
  logic       w_req;
  logic       w_wait_expire;
  logic [2:0] w_funct_alu_op;
  logic       w_funct_valid;

  mod_alu_funct_decode u_funct_decode (
    .i_funct  (bus.funct),
    .o_alu_op (w_funct_alu_op),
    .o_valid  (w_funct_valid)
  );

  assign w_dec_next = decode_next(bus.opcode);
  assign w_req      = w_mem_read | w_mem_write;
  // The current request cycle is the TIMEOUT-th one without mem_ready.
  assign w_wait_expire = (TIMEOUT > 0) && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode (mem_ready/zero gate a few outputs).
  always_comb begin
    w_next       = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_i_or_d     = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_en      = 1'b0;
    w_pc_source  = PCS_ALU;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_B;
    w_alu_op     = ALU_NOP;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write  = 1'b1;
          w_pc_en     = 1'b1;
          w_pc_source = PCS_ALU;
          w_alu_src_b = SRCB_FOUR;
          w_alu_op    = ALU_ADD;
          w_next      = ST_DECODE;
        end else if (w_wait_expire) begin
          w_next = ST_FAULT;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        w_alu_src_b = SRCB_IMM_SH;
        w_alu_op    = ALU_ADD;
        w_next      = w_dec_next;
        w_illegal   = (w_dec_next == ST_FETCH);
      end
      ST_R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_B;
        w_alu_op    = w_funct_alu_op;
        if (w_funct_valid) begin
          w_next = ST_R_WB;
        end else begin
          w_illegal = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_R_WB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALU_ADD;
        if (bus.opcode == OP_SW) begin
          w_next = ST_MEM_WR;
        end else begin
          w_next = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          w_next = ST_MEM_WB;
        end else if (w_wait_expire) begin
          w_next = ST_FAULT;
        end else begin
          w_next = ST_MEM_RD;
        end
      end
      ST_MEM_WB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next       = ST_FETCH;
      end
      ST_MEM_WR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_wait_expire) begin
          w_next = ST_FAULT;
        end else begin
          w_next = ST_MEM_WR;
        end
      end
      ST_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_B;
        w_alu_op    = ALU_SUB;
        w_pc_source = PCS_ALUOUT;
        w_pc_en     = bus.zero;
        w_retire    = 1'b1;
        w_next      = ST_FETCH;
      end
      ST_JUMP: begin
        w_pc_en     = 1'b1;
        w_pc_source = PCS_JUMP;
        w_retire    = 1'b1;
        w_next      = ST_FETCH;
      end
      ST_FAULT: begin
        w_next = ST_FAULT;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Memory wait counter: counts unanswered request cycles within one state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_next != r_state) begin
      r_wait_cnt <= '0;
    end else if (w_req && !bus.mem_ready) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1'b1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Sticky fault flag, set on entry to FAULT and cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_next == ST_FAULT) begin
      r_fault <= 1'b1;
    end else begin
      r_fault <= r_fault;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_count <= '0;
    end else if (w_retire) begin
      r_retire_count <= r_retire_count + RETIRE_W'(1'b1);
    end else begin
      r_retire_count <= r_retire_count;
    end
  end

  assign bus.mem_read     = w_mem_read;
  assign bus.mem_write    = w_mem_write;
  assign bus.i_or_d       = w_i_or_d;
  assign bus.ir_write     = w_ir_write;
  assign bus.pc_en        = w_pc_en;
  assign bus.pc_source    = w_pc_source;
  assign bus.alu_src_a    = w_alu_src_a;
  assign bus.alu_src_b    = w_alu_src_b;
  assign bus.alu_op       = w_alu_op;
  assign bus.reg_dst      = w_reg_dst;
  assign bus.mem_to_reg   = w_mem_to_reg;
  assign bus.reg_write    = w_reg_write;
  assign bus.retire       = w_retire;
  assign bus.illegal      = w_illegal;
  assign bus.fault        = r_fault;
  assign bus.retire_count = r_retire_count;

endmodule

// File: tb/tb_mod_multicycle_ctrl.sv
// Directed bench for mod_multicycle_ctrl: a per-cycle vector table for the
// zero-wait instruction mix, plus hand sequences for wait states, timeout
// fault and asynchronous abort.
module tb_mod_multicycle_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_rw;

  mod_multicycle_ctrl_if #(.RETIRE_W(16)) bus_if();

  mod_multicycle_ctrl #(.TIMEOUT(16), .RETIRE_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Packing order: mem_read mem_write i_or_d ir_write pc_en pc_source
  // alu_src_a alu_src_b alu_op reg_dst mem_to_reg reg_write retire illegal fault
  function automatic logic [18:0] pk(
    input logic mr, input logic mw, input logic iod, input logic irw,
    input logic pce, input logic [1:0] pcs, input logic sa, input logic [1:0] sb,
    input logic [2:0] alu, input logic rd, input logic m2r, input logic rw,
    input logic ret, input logic ill, input logic flt);
    return {mr, mw, iod, irw, pce, pcs, sa, sb, alu, rd, m2r, rw, ret, ill, flt};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus_if.mem_read, bus_if.mem_write, bus_if.i_or_d, bus_if.ir_write,
            bus_if.pc_en, bus_if.pc_source, bus_if.alu_src_a, bus_if.alu_src_b,
            bus_if.alu_op, bus_if.reg_dst, bus_if.mem_to_reg, bus_if.reg_write,
            bus_if.retire, bus_if.illegal, bus_if.fault};
  endfunction

  logic [18:0] e_idle, e_fwait, e_frdy, e_dec, e_dec_ill, e_rwb, e_madr;
  logic [18:0] e_mrd, e_mwb, e_mwr_wait, e_mwr_rdy, e_jump, e_fault;

  function automatic logic [18:0] e_rex(input logic [2:0] alu, input logic ill);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, alu,
              1'b0, 1'b0, 1'b0, 1'b0, ill, 1'b0);
  endfunction

  function automatic logic [18:0] e_br(input logic z);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, z, 2'b01, 1'b1, 2'b00, 3'b110,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic add_row(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy, input logic [18:0] exp);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check_vec(input string tag, input int idx, input logic [18:0] exp);
    logic [18:0] got;
    got = dut_vec();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: outputs got %05h want %05h", tag, idx, got, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Entered at posedge+1: drive, check at the falling edge, advance a cycle.
  task automatic apply(input vec_t v, input string tag, input int idx);
    bus_if.opcode    = v.op;
    bus_if.funct     = v.fn;
    bus_if.zero      = v.z;
    bus_if.mem_ready = v.rdy;
    #4;
    check_vec(tag, idx, v.exp);
    if (bus_if.reg_write === 1'b1) n_rw++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], tag, i);
    tbl.delete();
  endtask

  logic [5:0] op_r, op_lw, op_sw, op_beq, op_j, op_bad;
  logic [5:0] fn_list [5];
  logic [2:0] alu_list [5];

  initial begin
    n_cmp = 0; n_err = 0; n_rw = 0;
    op_r = 6'b000000; op_lw = 6'b100011; op_sw = 6'b101011;
    op_beq = 6'b000100; op_j = 6'b000010; op_bad = 6'b111111;
    fn_list[0] = 6'b100000; alu_list[0] = 3'b010;
    fn_list[1] = 6'b100010; alu_list[1] = 3'b110;
    fn_list[2] = 6'b100100; alu_list[2] = 3'b000;
    fn_list[3] = 6'b100101; alu_list[3] = 3'b001;
    fn_list[4] = 6'b101010; alu_list[4] = 3'b111;

    e_idle     = pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b101,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    e_fwait    = pk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b101,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    e_frdy     = pk(1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    e_dec      = pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    e_dec_ill  = pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
    e_rwb      = pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b101,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0);
    e_madr     = pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    e_mrd      = pk(1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b101,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    e_mwb      = pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b101,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0);
    e_mwr_wait = pk(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b101,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    e_mwr_rdy  = pk(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b101,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0);
    e_jump     = pk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b101,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0);
    e_fault    = pk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b101,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1);

    // Reset state
    rst_n = 1'b0;
    bus_if.opcode = 6'b000000; bus_if.funct = 6'b000000;
    bus_if.zero = 1'b0; bus_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_outputs", 0, e_idle);
    check_val("reset_retire_count", bus_if.retire_count, 16'd0);
    rst_n = 1'b1;

    // Zero-wait instruction mix; mem_ready/zero toggled where they must be ignored
    add_row(op_r, fn_list[0], 1'b1, 1'b1, e_idle);
    for (int k = 0; k < 5; k++) begin
      add_row(op_r, fn_list[k], 1'b0, 1'b1, e_frdy);
      add_row(op_r, fn_list[k], 1'b1, 1'b0, e_dec);
      add_row(op_r, fn_list[k], 1'b1, 1'b1, e_rex(alu_list[k], 1'b0));
      add_row(op_r, fn_list[k], 1'b0, 1'b1, e_rwb);
    end
    add_row(op_lw, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_lw, 6'b000000, 1'b0, 1'b0, e_dec);
    add_row(op_lw, 6'b000000, 1'b1, 1'b1, e_madr);
    add_row(op_lw, 6'b000000, 1'b0, 1'b1, e_mrd);
    add_row(op_lw, 6'b000000, 1'b0, 1'b1, e_mwb);
    add_row(op_sw, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_sw, 6'b000000, 1'b0, 1'b1, e_dec);
    add_row(op_sw, 6'b000000, 1'b0, 1'b0, e_madr);
    add_row(op_sw, 6'b000000, 1'b0, 1'b1, e_mwr_rdy);
    add_row(op_beq, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_beq, 6'b000000, 1'b0, 1'b1, e_dec);
    add_row(op_beq, 6'b000000, 1'b1, 1'b0, e_br(1'b1));
    add_row(op_beq, 6'b000000, 1'b1, 1'b1, e_frdy);
    add_row(op_beq, 6'b000000, 1'b1, 1'b1, e_dec);
    add_row(op_beq, 6'b000000, 1'b0, 1'b1, e_br(1'b0));
    add_row(op_j, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_j, 6'b000000, 1'b0, 1'b1, e_dec);
    add_row(op_j, 6'b000000, 1'b1, 1'b0, e_jump);
    add_row(op_bad, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_bad, 6'b000000, 1'b0, 1'b1, e_dec_ill);
    add_row(op_r, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_r, 6'b000000, 1'b0, 1'b1, e_dec);
    add_row(op_r, 6'b000000, 1'b0, 1'b1, e_rex(3'b101, 1'b1));
    run_tbl("mix");
    check_val("mix_retire_count", bus_if.retire_count, 16'd10);

    // lw with 3 wait cycles in both FETCH and MEM_RD: 11 cycles, one writeback
    n_rw = 0;
    for (int k = 0; k < 3; k++) add_row(op_lw, 6'b000000, 1'b0, 1'b0, e_fwait);
    add_row(op_lw, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_lw, 6'b000000, 1'b0, 1'b0, e_dec);
    add_row(op_lw, 6'b000000, 1'b0, 1'b0, e_madr);
    for (int k = 0; k < 3; k++) add_row(op_lw, 6'b000000, 1'b0, 1'b0, e_mrd);
    add_row(op_lw, 6'b000000, 1'b0, 1'b1, e_mrd);
    add_row(op_lw, 6'b000000, 1'b0, 1'b0, e_mwb);
    run_tbl("lw_wait");
    check_val("lw_wait_reg_write_count", n_rw[15:0], 16'd1);
    check_val("lw_wait_retire_count", bus_if.retire_count, 16'd11);

    // sw with mem_ready stuck low: 16 write-wait cycles, then sticky FAULT
    add_row(op_sw, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_sw, 6'b000000, 1'b0, 1'b0, e_dec);
    add_row(op_sw, 6'b000000, 1'b0, 1'b0, e_madr);
    for (int k = 0; k < 16; k++) add_row(op_sw, 6'b000000, 1'b0, 1'b0, e_mwr_wait);
    add_row(op_sw, 6'b000000, 1'b0, 1'b0, e_fault);
    add_row(op_sw, 6'b000000, 1'b0, 1'b1, e_fault);
    add_row(op_sw, 6'b000000, 1'b1, 1'b1, e_fault);
    run_tbl("timeout");
    check_val("timeout_retire_count", bus_if.retire_count, 16'd11);
    rst_n = 1'b0;
    #1;
    check_vec("fault_cleared_by_reset", 0, e_idle);
    check_val("fault_reset_retire_count", bus_if.retire_count, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // j retires, then sw aborted by reset while mem_ready is pending
    add_row(op_j, 6'b000000, 1'b0, 1'b0, e_idle);
    add_row(op_j, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_j, 6'b000000, 1'b0, 1'b1, e_dec);
    add_row(op_j, 6'b000000, 1'b0, 1'b1, e_jump);
    add_row(op_sw, 6'b000000, 1'b0, 1'b1, e_frdy);
    add_row(op_sw, 6'b000000, 1'b0, 1'b1, e_dec);
    add_row(op_sw, 6'b000000, 1'b0, 1'b1, e_madr);
    run_tbl("abort");
    check_val("abort_pre_retire_count", bus_if.retire_count, 16'd1);
    bus_if.mem_ready = 1'b0;
    #2;
    bus_if.mem_ready = 1'b1;
    #1;
    check_vec("abort_mem_wr_ready", 0, e_mwr_rdy);
    rst_n = 1'b0;
    #1;
    check_vec("abort_async_outputs", 0, e_idle);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("abort_retire_count", bus_if.retire_count, 16'd0);
    add_row(op_r, fn_list[0], 1'b0, 1'b1, e_idle);
    add_row(op_r, fn_list[0], 1'b0, 1'b1, e_frdy);
    run_tbl("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_multicycle_ctrl.md
Name: mod_multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath's mux selects, ALU op, register-file, IR and PC enables, and a req/ready handshake to the unified memory. It supports R-type add/sub/and/or/slt, lw, sw, beq and j. Opcode and funct come from the instruction register; the existing single-cycle control decoder is not used in this build.

Parameters:
TIMEOUT, 16, max cycles waiting on mem_ready before fault; 0 disables timeout.
RETIRE_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  address mux: 0=PC, 1=ALUOut
ir_write  out  1  load IR
pc_en  out  1  PC load = pc_write | (pc_write_cond & zero)
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_src_a  out  1  0=PC, 1=A reg
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 101 nop
reg_dst  out  1  1=rd, 0=rt
mem_to_reg  out  1  1=MDR, 0=ALUOut
reg_write  out  1  register-file write enable
retire  out  1  one-cycle pulse when an instruction completes
illegal  out  1  one-cycle pulse on unsupported opcode/funct
fault  out  1  sticky memory-timeout fault
retire_count  out  RETIRE_W  completed instruction count, wraps

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE. Wait counter, retire_count and fault clear to 0.
- IDLE: all outputs are 0, alu_op=101. Moves to FETCH on the first clock after rst_n deasserts.
- Outputs not listed for a state are 0; alu_op defaults to 101.
- FETCH: mem_read=1, i_or_d=0. Stay until mem_ready. In the mem_ready cycle: ir_write=1, pc_en=1, pc_source=00, alu_src_a=0, alu_src_b=01, alu_op=010, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=010 (branch target into ALUOut). Next state:
  - R -> R_EXEC
  - lw/sw -> MEM_ADDR
  - beq -> BRANCH
  - j -> JUMP
  - any other opcode -> FETCH, with illegal=1 this cycle.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct (add/sub/and/or/slt). Unknown funct: illegal=1, go to FETCH with no writeback. Otherwise go to R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, retire=1, then FETCH. slt writes unconditionally.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, retire=1, then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait for mem_ready; retire=1 in the ready cycle, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_source=01, pc_en=zero, retire=1, then FETCH.
- JUMP: pc_en=1, pc_source=10, retire=1, then FETCH.
- Memory handshake:
  - Request stays asserted and stable until mem_ready.
  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
  - mem_ready in the first request cycle completes with zero wait.
- Timeout (TIMEOUT>0):
  - The wait counter increments each request cycle without mem_ready and clears on state change.
  - When it reaches TIMEOUT, go to FAULT: fault=1 (sticky), all other outputs 0.
  - FAULT is left only by reset.
- retire_count increments on every retire pulse and wraps at 2^RETIRE_W. retire and illegal are never high together.
- Latency at zero-wait memory: R=4, lw=5, sw=4, beq=3, j=3 cycles.
- rst_n asserted mid-instruction aborts immediately, with no further writes. Outputs are Moore-decoded from state, plus mem_ready gating in FETCH/MEM_WR and zero gating in BRANCH.

Decomposition:
- Shared package/include holds:
  - opcode/funct constants (r=000000, lw=100011, sw=101011, beq=000100, j=000010; funct add=100000, sub=100010, and=100100, or=100101, slt=101010)
  - alu_op encodings
  - state encoding
- One sub-module, mod_alu_funct_decode: combinational funct -> alu_op plus a valid flag, used in R_EXEC.

Test Plan:
- Reset, then add with mem_ready tied 1: states IDLE,FETCH,DECODE,R_EXEC,R_WB; reg_write=1 and reg_dst=1 in cycle 5; retire_count=1.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_RD: mem_read held 4 cycles each; mem_to_reg=1 and reg_write=1 once; total 11 cycles.
- beq with zero=1, then beq with zero=0: pc_en=1 with pc_source=01 in the first; pc_en=0 in the second; both retire.
- Opcode 111111, then R-type with funct 000000: each produces one illegal pulse, no reg_write, no retire, and returns to FETCH.
- TIMEOUT=16 and mem_ready held 0 in MEM_WR: fault rises after 16 wait cycles, mem_write drops, state is stuck until rst_n pulse, and fault then clears.
- rst_n asserted during MEM_WR with mem_ready pending: outputs go to 0 asynchronously; retire_count is 0 after release.
